wave_capture_writer: RTL

WAVE_CAPTURE_WRITER -- requirements
Module: wave_capture_writer

---
 rtl/wave_capture_writer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wave_capture_writer.sv
// Trigger-based waveform capture writer: streams ADC samples into a circular
// RAM, holds a fixed pre-trigger history and stops once the post-trigger part
// of the window has been written.
module wave_capture_writer #(
  parameter int unsigned c_ADDR_WIDTH = 10,
  parameter int unsigned c_DATA_WIDTH = 8,
  parameter int unsigned c_PRE_TRIG   = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic                    force_trig,
  input  logic                    trig_edge,
  input  logic [c_DATA_WIDTH-1:0] trig_level,
  input  logic                    adc_valid,
  input  logic [c_DATA_WIDTH-1:0] adc_data,
  output logic                    wr_en,
  output logic [c_ADDR_WIDTH-1:0] wr_addr,
  output logic [c_DATA_WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [c_ADDR_WIDTH-1:0] trig_addr,
  output logic [c_ADDR_WIDTH-1:0] start_addr
);

  localparam int unsigned DEPTH = 2 ** c_ADDR_WIDTH;
  localparam logic [c_ADDR_WIDTH-1:0] ADDR_ONE  = c_ADDR_WIDTH'(1);
  localparam logic [c_ADDR_WIDTH-1:0] PRE_OFS   = c_ADDR_WIDTH'(c_PRE_TRIG);
  localparam logic [c_ADDR_WIDTH-1:0] PRE_LAST  = c_ADDR_WIDTH'(c_PRE_TRIG - 1);
  localparam logic [c_ADDR_WIDTH-1:0] POST_LAST = c_ADDR_WIDTH'(DEPTH - c_PRE_TRIG - 2);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t                  state, next_state;
  logic [c_ADDR_WIDTH-1:0] ptr;
  logic [c_ADDR_WIDTH-1:0] cnt;
  logic [c_DATA_WIDTH-1:0] prev;
  logic                    prev_valid;
  logic                    accept;
  logic                    arm_ok;
  logic                    hit;
  logic                    rise;
  logic                    fall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state, sample acceptance and trigger detection
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    accept     = 1'b0;
    arm_ok     = 1'b0;
    hit        = 1'b0;
    rise       = prev_valid && (prev <  trig_level) && (adc_data >= trig_level);
    fall       = prev_valid && (prev >= trig_level) && (adc_data <  trig_level);
    case (state)
      S_IDLE, S_DONE: begin
        arm_ok = arm;
        if (arm) next_state = S_PRE;
      end
      S_PRE: begin
        busy   = 1'b1;
        accept = adc_valid;
        if (adc_valid && (cnt == PRE_LAST)) next_state = S_ARMED;
      end
      S_ARMED: begin
        busy   = 1'b1;
        accept = adc_valid;
        hit    = adc_valid && (force_trig || (trig_edge ? fall : rise));
        if (hit) next_state = S_POST;
      end
      S_POST: begin
        busy   = 1'b1;
        accept = adc_valid;
        if (adc_valid && (cnt == POST_LAST)) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Write port, pointers, counters and trigger bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      ptr        <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (arm_ok) begin
        done       <= 1'b0;
        ptr        <= '0;
        cnt        <= '0;
        prev_valid <= 1'b0;
      end
      if (accept) begin
        wr_en      <= 1'b1;
        wr_addr    <= ptr;
        wr_data    <= adc_data;
        ptr        <= ptr + ADDR_ONE;
        prev       <= adc_data;
        prev_valid <= 1'b1;
        // cnt counts PRE writes, rests at zero through ARMED, then counts POST writes
        if (state == S_PRE)  cnt <= (cnt == PRE_LAST) ? '0 : cnt + ADDR_ONE;
        if (state == S_POST) cnt <= cnt + ADDR_ONE;
      end
      if (hit) begin
        trig_addr  <= ptr;
        start_addr <= ptr - PRE_OFS;
      end
      if ((state == S_POST) && (next_state == S_DONE)) done <= 1'b1;
    end
  end

endmodule
